// File: rtl/aes_pkg.sv
// Shared types for the AES host stream front end and its control interface to aes_top.
package aes_pkg;

  typedef logic [31:0]  aes_32;
  typedef logic [127:0] aes_128;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_KEY_GEN = 2'd1,
    OP_ENC     = 2'd2
  } opcode;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_KEY_START = 3'd1,
    ST_KEY_WAIT  = 3'd2,
    ST_COLLECT   = 3'd3,
    ST_ENC_START = 3'd4,
    ST_ENC_WAIT  = 3'd5,
    ST_DRAIN     = 3'd6
  } if_state_e;

endpackage

// File: rtl/aes_word_pack.sv
// 4x32 shift register with a word counter; shifts toward the MSB so the first word lands in [127:96].
// Same-cycle update on clear/load/shift; the caller owns all flow control.
module aes_word_pack
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [127:0] load_dat_i,
  input  logic         shift_i,
  input  logic [31:0]  shift_dat_i,
  output logic [127:0] blk_o,
  output logic [1:0]   cnt_o
);

  aes_128     blk_q, blk_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    blk_d = blk_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      blk_d = '0;
      cnt_d = '0;
    end else if (load_i) begin
      blk_d = load_dat_i;
      cnt_d = '0;
    end else if (shift_i) begin
      blk_d = {blk_q[95:0], shift_dat_i};
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q <= '0;
      cnt_q <= '0;
    end else begin
      blk_q <= blk_d;
      cnt_q <= cnt_d;
    end
  end

  assign blk_o = blk_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/aes_stream_if.sv
// Host front end for aes_top: packs 4x32 plaintext words, runs key gen then one encrypt per block, unpacks ciphertext.
// start_o follows the 4th input word by one cycle (more while busy_i); input stalls until the block has fully drained.
module aes_stream_if
  import aes_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_i,
  input  logic         key_load_i,
  output logic         cfg_ready_o,
  input  logic [31:0]  s_data_i,
  input  logic         s_valid_i,
  output logic         s_ready_o,
  output logic [31:0]  m_data_o,
  output logic         m_valid_o,
  input  logic         m_ready_i,
  output opcode        opcode_o,
  output logic         start_o,
  output logic [127:0] key_o,
  output logic [127:0] plain_text_o,
  input  logic         busy_i,
  input  logic         key_ready_i,
  input  logic         cipher_ready_i,
  input  logic [127:0] cipher_i,
  output logic         key_valid_o,
  output logic         err_o
);

  if_state_e        state_q, state_d;
  aes_128           key_q, key_d;
  logic             key_valid_q, key_valid_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;

  aes_128     in_blk, out_blk;
  logic [1:0] in_cnt, out_cnt;
  logic       in_shift, out_load, out_shift, key_accept;
  logic       in_wait, wdog_last, key_timeout, enc_timeout;
  logic       unused_out_tail;

  assign key_accept  = cfg_ready_o && key_load_i;
  assign in_shift    = s_valid_i && s_ready_o;
  assign out_load    = (state_q == ST_ENC_WAIT) && cipher_ready_i;
  assign out_shift   = m_valid_o && m_ready_i;

  // The start cycle counts toward the budget, so err_o rises TIMEOUT_CYCLES cycles after start_o.
  assign in_wait     = (state_q == ST_KEY_WAIT) || (state_q == ST_ENC_WAIT);
  assign wdog_last   = (wdog_q <= CNT_W'(1));
  assign key_timeout = (state_q == ST_KEY_WAIT) && !key_ready_i && wdog_last;
  assign enc_timeout = (state_q == ST_ENC_WAIT) && !cipher_ready_i && wdog_last;

  aes_word_pack u_in_pack (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (state_q == ST_KEY_START),
    .load_i      (1'b0),
    .load_dat_i  ('0),
    .shift_i     (in_shift),
    .shift_dat_i (s_data_i),
    .blk_o       (in_blk),
    .cnt_o       (in_cnt)
  );

  aes_word_pack u_out_pack (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (1'b0),
    .load_i      (out_load),
    .load_dat_i  (cipher_i),
    .shift_i     (out_shift),
    .shift_dat_i ('0),
    .blk_o       (out_blk),
    .cnt_o       (out_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (key_load_i)       state_d = ST_KEY_START;
        else if (key_valid_q) state_d = ST_COLLECT;
      end
      ST_KEY_START: state_d = ST_KEY_WAIT;
      ST_KEY_WAIT: begin
        if (key_ready_i)      state_d = ST_COLLECT;
        else if (key_timeout) state_d = ST_IDLE;
      end
      ST_COLLECT: begin
        if (key_accept)                         state_d = ST_KEY_START;
        else if (in_shift && in_cnt == 2'd3)    state_d = ST_ENC_START;
      end
      ST_ENC_START: begin
        if (!busy_i) state_d = ST_ENC_WAIT;
      end
      ST_ENC_WAIT: begin
        if (cipher_ready_i)   state_d = ST_DRAIN;
        else if (enc_timeout) state_d = ST_IDLE;
      end
      ST_DRAIN: begin
        if (out_shift && out_cnt == 2'd3) state_d = ST_COLLECT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    opcode_o    = OP_NOP;
    start_o     = 1'b0;
    cfg_ready_o = 1'b0;
    s_ready_o   = 1'b0;
    m_valid_o   = 1'b0;
    case (state_q)
      ST_IDLE: cfg_ready_o = 1'b1;
      ST_KEY_START: begin
        opcode_o = OP_KEY_GEN;
        start_o  = 1'b1;
      end
      ST_COLLECT: begin
        // A key load at a block boundary takes priority over the data word.
        cfg_ready_o = (in_cnt == 2'd0);
        s_ready_o   = !((in_cnt == 2'd0) && key_load_i);
      end
      ST_ENC_START: begin
        opcode_o = OP_ENC;
        start_o  = !busy_i;
      end
      ST_DRAIN: m_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    key_d       = key_q;
    key_valid_d = key_valid_q;
    err_d       = err_q | key_timeout | enc_timeout;
    wdog_d      = wdog_q;
    if (key_accept) key_d = key_i;
    if (state_q == ST_KEY_START)                    key_valid_d = 1'b0;
    else if (state_q == ST_KEY_WAIT && key_ready_i) key_valid_d = 1'b1;
    if (start_o)                       wdog_d = CNT_W'(TIMEOUT_CYCLES - 1);
    else if (in_wait && wdog_q != '0)  wdog_d = wdog_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '0;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      wdog_q      <= '0;
    end else begin
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      err_q       <= err_d;
      wdog_q      <= wdog_d;
    end
  end

  assign key_o           = key_q;
  assign plain_text_o    = in_blk;
  assign m_data_o        = out_blk[127:96];
  assign key_valid_o     = key_valid_q;
  assign err_o           = err_q;
  assign unused_out_tail = ^out_blk[95:0];

endmodule

// File: tb/tb_aes_stream_if.sv
// Scoreboard bench for aes_stream_if with a stub core answering start_o pulses.
module tb_aes_stream_if;
  import aes_pkg::*;

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_i;
  logic         key_load_i, cfg_ready_o;
  logic [31:0]  s_data_i;
  logic         s_valid_i, s_ready_o;
  logic [31:0]  m_data_o;
  logic         m_valid_o, m_ready_i;
  opcode        opcode_o;
  logic         start_o;
  logic [127:0] key_o, plain_text_o;
  logic         busy_i, key_ready_i, cipher_ready_i;
  logic [127:0] cipher_i;
  logic         key_valid_o, err_o;

  aes_stream_if #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .key_i(key_i), .key_load_i(key_load_i), .cfg_ready_o(cfg_ready_o),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
    .opcode_o(opcode_o), .start_o(start_o), .key_o(key_o), .plain_text_o(plain_text_o),
    .busy_i(busy_i), .key_ready_i(key_ready_i), .cipher_ready_i(cipher_ready_i),
    .cipher_i(cipher_i), .key_valid_o(key_valid_o), .err_o(err_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed { opcode op; logic [127:0] dat; } start_t;
  start_t      exp_start[$];
  logic [31:0] exp_word[$];
  start_t      e_start;
  logic [31:0] e_word, held;
  int          checks = 0, failures = 0;
  int          cyc = 0, last_start_cyc = 0;
  int          key_cd = 0, enc_cd = 0;
  bit          prev_start = 0, prev_stall = 0, stub_hang = 0;
  logic [127:0] stub_cipher = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // 0: key_valid_o, 1: drain finished, 2: err_o, 3: m_valid_o
  task automatic wait_for(input int which, input int budget, input string name);
    bit hit = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      case (which)
        0: hit = key_valid_o;
        1: hit = (exp_word.size() == 0) && !m_valid_o;
        2: hit = err_o;
        default: hit = m_valid_o;
      endcase
    end
    if (!hit) begin
      checks++; failures++;
      $display("FAIL %s timeout after %0d cycles", name, budget);
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    bit hs = 0;
    s_valid_i = 1'b1;
    s_data_i  = w;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = s_ready_o;
      tick();
    end
    s_valid_i = 1'b0;
    if (!hs) begin
      checks++; failures++;
      $display("FAIL send_word %h not accepted", w);
    end
  endtask

  task automatic push_block(input logic [127:0] blk, input logic [127:0] c, input bit expect_out);
    exp_start.push_back('{op: OP_ENC, dat: blk});
    stub_cipher = c;
    if (expect_out) begin
      exp_word.push_back(c[127:96]);
      exp_word.push_back(c[95:64]);
      exp_word.push_back(c[63:32]);
      exp_word.push_back(c[31:0]);
    end
  endtask

  task automatic send_block(input logic [127:0] blk);
    send_word(blk[127:96]);
    send_word(blk[95:64]);
    send_word(blk[63:32]);
    send_word(blk[31:0]);
  endtask

  task automatic reset_checks(input string tag);
    chk1({tag, "_cfg_ready"}, cfg_ready_o, 1'b1);
    chk1({tag, "_s_ready"}, s_ready_o, 1'b0);
    chk1({tag, "_m_valid"}, m_valid_o, 1'b0);
    chk1({tag, "_start"}, start_o, 1'b0);
    check({tag, "_opcode"}, 128'(opcode_o), 128'(OP_NOP));
    chk1({tag, "_key_valid"}, key_valid_o, 1'b0);
    chk1({tag, "_err"}, err_o, 1'b0);
    check({tag, "_key"}, key_o, 128'h0);
    check({tag, "_plain"}, plain_text_o, 128'h0);
    check({tag, "_m_data"}, 128'(m_data_o), 128'h0);
  endtask

  task automatic load_key(input logic [127:0] k);
    exp_start.push_back('{op: OP_KEY_GEN, dat: k});
    key_i      = k;
    key_load_i = 1'b1;
    tick();
    key_load_i = 1'b0;
  endtask

  // Stub core: answers key gen after 10 cycles and encrypt after 5 unless told to hang.
  initial begin
    key_ready_i = 1'b0; cipher_ready_i = 1'b0; cipher_i = '0;
    forever begin
      @(negedge clk);
      key_ready_i = 1'b0;
      cipher_ready_i = 1'b0;
      if (key_cd > 0) begin
        key_cd--;
        if (key_cd == 0) key_ready_i = 1'b1;
      end
      if (enc_cd > 0) begin
        enc_cd--;
        if (enc_cd == 0) begin cipher_ready_i = 1'b1; cipher_i = stub_cipher; end
      end
      if (start_o && opcode_o == OP_KEY_GEN) key_cd = 10;
      if (start_o && opcode_o == OP_ENC && !stub_hang) enc_cd = 5;
      if (rst) begin key_cd = 0; enc_cd = 0; end
    end
  end

  // Monitor: checks every start pulse and every output handshake against the queues.
  always @(negedge clk) begin
    if (rst) begin
      prev_start = 0;
      prev_stall = 0;
    end else begin
      if (start_o) begin
        chk1("start_back_to_back", prev_start, 1'b0);
        if (exp_start.size() == 0) begin
          checks++; failures++;
          $display("FAIL start_unexpected opcode=%0d required=none", opcode_o);
        end else begin
          e_start = exp_start.pop_front();
          check("start_opcode", 128'(opcode_o), 128'(e_start.op));
          check("start_block", (e_start.op == OP_KEY_GEN) ? key_o : plain_text_o, e_start.dat);
        end
        last_start_cyc = cyc;
      end
      prev_start = start_o;
      if (prev_stall) begin
        chk1("m_valid_hold", m_valid_o, 1'b1);
        check("m_data_hold", 128'(m_data_o), 128'(held));
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_word.size() == 0) begin
          checks++; failures++;
          $display("FAIL m_word_unexpected actual=%h required=none", m_data_o);
        end else begin
          e_word = exp_word.pop_front();
          check("m_word", 128'(m_data_o), 128'(e_word));
        end
      end
      prev_stall = m_valid_o && !m_ready_i;
      held = m_data_o;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst = 1'b1; key_i = '0; key_load_i = 1'b0; s_data_i = '0; s_valid_i = 1'b0;
    m_ready_i = 1'b1; busy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_checks("reset");

    // Key load and expansion
    tick();
    load_key(KEY0);
    wait_for(0, 40, "key_expand");
    chk1("key_s_ready", s_ready_o, 1'b1);
    check("key_o", key_o, KEY0);

    // Single block with start latency of one cycle
    tick();
    push_block(128'h00112233_44556677_8899aabb_ccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1);
    send_block(128'h00112233_44556677_8899aabb_ccddeeff);
    @(negedge clk);
    chk1("enc_start_latency", start_o, 1'b1);
    wait_for(1, 100, "blk1_drain");

    // Output backpressure: 5-cycle stall before every other word
    tick();
    m_ready_i = 1'b0;
    push_block(128'hdeadbeef_01234567_89abcdef_0badf00d, 128'hffeeddcc_bbaa9988_77665544_33221100, 1);
    send_block(128'hdeadbeef_01234567_89abcdef_0badf00d);
    wait_for(3, 50, "bp_valid");
    tick();
    for (int k = 0; k < 4; k++) begin
      m_ready_i = 1'b0;
      if (k % 2 == 0) begin
        repeat (5) begin
          @(negedge clk);
          chk1("bp_s_ready", s_ready_o, 1'b0);
          tick();
        end
      end
      m_ready_i = 1'b1;
      @(negedge clk);
      chk1("bp_valid_at_hs", m_valid_o, 1'b1);
      tick();
    end
    @(negedge clk);
    chk1("bp_done_valid", m_valid_o, 1'b0);
    chk1("bp_done_s_ready", s_ready_o, 1'b1);
    check("bp_queue_empty", 128'(exp_word.size()), 128'h0);

    // Watchdog: core never completes
    tick();
    stub_hang = 1'b1;
    push_block(128'h11111111_22222222_33333333_44444444, 128'h0, 0);
    send_block(128'h11111111_22222222_33333333_44444444);
    wait_for(2, 200, "wdog_err");
    check("wdog_latency", 128'(cyc - last_start_cyc), 128'd64);
    chk1("wdog_key_valid", key_valid_o, 1'b1);
    chk1("wdog_idle_cfg_ready", cfg_ready_o, 1'b1);
    chk1("wdog_idle_s_ready", s_ready_o, 1'b0);
    stub_hang = 1'b0;
    tick();
    push_block(128'h55555555_66666666_77777777_88888888, 128'h0f0e0d0c_0b0a0908_07060504_03020100, 1);
    send_block(128'h55555555_66666666_77777777_88888888);
    wait_for(1, 100, "after_wdog_drain");
    chk1("err_sticky", err_o, 1'b1);

    // Busy holds the encrypt start for 3 cycles
    tick();
    push_block(128'ha0a0a0a0_b1b1b1b1_c2c2c2c2_d3d3d3d3, 128'h12345678_9abcdef0_0fedcba9_87654321, 1);
    send_word(32'ha0a0a0a0);
    send_word(32'hb1b1b1b1);
    send_word(32'hc2c2c2c2);
    busy_i = 1'b1;
    send_word(32'hd3d3d3d3);
    repeat (3) begin
      @(negedge clk);
      chk1("busy_no_start", start_o, 1'b0);
      tick();
    end
    busy_i = 1'b0;
    @(negedge clk);
    chk1("busy_release_start", start_o, 1'b1);
    wait_for(1, 100, "busy_drain");

    // Key load collides with a data word at count 0
    tick();
    exp_start.push_back('{op: OP_KEY_GEN, dat: KEY1});
    key_i = KEY1; key_load_i = 1'b1;
    s_data_i = 32'hcafef00d; s_valid_i = 1'b1;
    @(negedge clk);
    chk1("coll_s_ready", s_ready_o, 1'b0);
    chk1("coll_cfg_ready", cfg_ready_o, 1'b1);
    tick();
    key_load_i = 1'b0; s_valid_i = 1'b0;
    wait_for(0, 40, "coll_key_expand");
    check("coll_key_o", key_o, KEY1);
    tick();
    push_block(128'h01010101_02020202_03030303_04040404, 128'haaaaaaaa_bbbbbbbb_cccccccc_dddddddd, 1);
    send_block(128'h01010101_02020202_03030303_04040404);
    wait_for(1, 100, "coll_drain");

    // Reset after two words, then a full block is needed again
    tick();
    send_word(32'hdead0001);
    send_word(32'hdead0002);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    reset_checks("midrst");
    tick();
    load_key(KEY0);
    wait_for(0, 40, "midrst_key_expand");
    tick();
    push_block(128'hbbbb0001_bbbb0002_bbbb0003_bbbb0004, 128'h31323334_35363738_393a3b3c_3d3e3f40, 1);
    send_word(32'hbbbb0001);
    send_word(32'hbbbb0002);
    send_word(32'hbbbb0003);
    repeat (4) begin
      @(negedge clk);
      chk1("midrst_no_early_start", start_o, 1'b0);
      tick();
    end
    send_word(32'hbbbb0004);
    wait_for(1, 100, "midrst_drain");

    check("final_start_queue", 128'(exp_start.size()), 128'h0);
    check("final_word_queue", 128'(exp_word.size()), 128'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
